// File: rtl/vtiming_gen.sv
// rtl/vtiming_gen.sv - vertical blanking/sync/frame-tick generator
//
// Purpose: sits behind the vertical line counter and turns its line count
// into registered VBLANK/VSYNC (both polarities), a one-clock FRAME_TICK at
// the start of line 0, and an optional sticky frame-length error flag.
// All outputs are flops, updated on the same edge the counter advances.
//
// Optional feature macro: VTIMING_CHECK_EN (frame-length checker driving
// TIMING_ERR; when undefined TIMING_ERR is tied low).
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET_N    in   synchronous active-low reset
//   HRESET     in   line-advance strobe, one CLK per line
//   VRESET     in   high while the counter holds line LINES-1
//   VCNT[8:0]  in   current line number
//   VBLANK     out  vertical blanking, active high
//   VBLANK_N   out  complement of VBLANK
//   VSYNC      out  vertical sync, active high
//   VSYNC_N    out  complement of VSYNC
//   FRAME_TICK out  one-CLK pulse on the first clock of line 0
//   TIMING_ERR out  sticky frame-length error

module vtiming_gen #(
  parameter int LINES       = 262,
  parameter int VSYNC_START = 4,
  parameter int VSYNC_END   = 8,
  parameter int VBLANK_END  = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       HRESET,
  input  logic       VRESET,
  input  logic [8:0] VCNT,
  output logic       VBLANK,
  output logic       VBLANK_N,
  output logic       VSYNC,
  output logic       VSYNC_N,
  output logic       FRAME_TICK,
  output logic       TIMING_ERR
);

  // The line count is 9 bits wide, so a frame can hold at most 512 lines.
  if (!(VSYNC_START >= 1 && VSYNC_START < VSYNC_END &&
        VSYNC_END <= VBLANK_END && VBLANK_END < LINES && LINES <= 512)) begin : g_param_err
    $error("vtiming_gen: illegal vertical timing parameters");
  end

  localparam logic [9:0] VS_LINE = 10'(VSYNC_START);
  localparam logic [9:0] VE_LINE = 10'(VSYNC_END);
  localparam logic [9:0] BE_LINE = 10'(VBLANK_END);
  // With no back porch the sync period ends directly in the visible area.
  localparam bit NO_POST = (VSYNC_END == VBLANK_END);

  typedef enum logic [1:0] {
    BLANK_PRE  = 2'd0,
    SYNC       = 2'd1,
    BLANK_POST = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [9:0] next_line;
  logic       frame_tick_d;

  always_comb begin
    state_d      = state_q;
    next_line    = 10'd0;
    frame_tick_d = 1'b0;
    if (HRESET) begin
      // 10-bit sum so line 511 does not wrap onto a threshold.
      next_line = VRESET ? 10'd0 : ({1'b0, VCNT} + 10'd1);
      if (VRESET) begin
        state_d      = BLANK_PRE;
        frame_tick_d = 1'b1;
      end else begin
        case (state_q)
          BLANK_PRE:  if (next_line == VS_LINE) state_d = SYNC;
          SYNC:       if (next_line == VE_LINE) state_d = NO_POST ? ACTIVE : BLANK_POST;
          BLANK_POST: if (next_line == BE_LINE) state_d = ACTIVE;
          default:    state_d = state_q;
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the new VCNT.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= BLANK_PRE;
      VBLANK     <= 1'b1;
      VBLANK_N   <= 1'b0;
      VSYNC      <= 1'b0;
      VSYNC_N    <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      state_q    <= state_d;
      VBLANK     <= (state_d != ACTIVE);
      VBLANK_N   <= (state_d == ACTIVE);
      VSYNC      <= (state_d == SYNC);
      VSYNC_N    <= (state_d != SYNC);
      FRAME_TICK <= frame_tick_d;
    end
  end

`ifdef VTIMING_CHECK_EN
  logic [9:0] line_cnt_q;
  logic       seen_vreset_q;
  logic       timing_err_q;

  // line_cnt_q counts line advances since the last frame start; at the
  // closing VRESET edge it holds LINES-1 for a correctly sized frame.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      line_cnt_q    <= 10'd0;
      seen_vreset_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else if (HRESET) begin
      if (VRESET) begin
        line_cnt_q    <= 10'd0;
        seen_vreset_q <= 1'b1;
        // First frame after reset started at an unknown line: not judged.
        if (seen_vreset_q && ((line_cnt_q + 10'd1) != 10'(LINES)))
          timing_err_q <= 1'b1;
      end else begin
        line_cnt_q <= line_cnt_q + 10'd1;
      end
    end
  end

  assign TIMING_ERR = timing_err_q;
`else
  assign TIMING_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_vtiming_gen.sv
// tb/tb_vtiming_gen.sv - randomized self-checking bench for vtiming_gen

module tb_vtiming_gen;

  logic       clk = 1'b0;
  logic       rstn;
  logic       hres;
  logic       vres_a, vres_b;
  logic [8:0] vcnt_a, vcnt_b;
  logic       vb_a, vbn_a, vs_a, vsn_a, ft_a, err_a;
  logic       vb_b, vbn_b, vs_b, vsn_b, ft_b, err_b;

  int errors = 0;
  int checks = 0;

  // Reference state: line number each counter holds, "blank until next frame"
  // flag after a mid-frame reset, and frame-length error bookkeeping.
  int line_a = 0, line_b = 0;
  int last_a = 261;
  bit pend_a = 0, pend_b = 0;
  bit merr_a = 0, merr_b = 0;
  bit seen_a = 0, seen_b = 0;
  int len_a  = 0, len_b  = 0;
  bit ft_exp_a, ft_exp_b;

  always #5 clk = ~clk;

  vtiming_gen u_dut_a (
    .CLK(clk), .RESET_N(rstn), .HRESET(hres), .VRESET(vres_a), .VCNT(vcnt_a),
    .VBLANK(vb_a), .VBLANK_N(vbn_a), .VSYNC(vs_a), .VSYNC_N(vsn_a),
    .FRAME_TICK(ft_a), .TIMING_ERR(err_a)
  );

  vtiming_gen #(.LINES(20), .VSYNC_START(2), .VSYNC_END(16), .VBLANK_END(16)) u_dut_b (
    .CLK(clk), .RESET_N(rstn), .HRESET(hres), .VRESET(vres_b), .VCNT(vcnt_b),
    .VBLANK(vb_b), .VBLANK_N(vbn_b), .VSYNC(vs_b), .VSYNC_N(vsn_b),
    .FRAME_TICK(ft_b), .TIMING_ERR(err_b)
  );

  task automatic chk(input string tag, input int line, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s line=%0d got=%b expected=%b", tag, line, got, exp);
    end
  endtask

  // Advance one line model for an edge with the given strobes.
  task automatic model(inout int line, inout bit pend, inout bit merr, inout bit seen,
                       inout int len, input bit h, input bit vr, input bit rst,
                       input int lines, input int vs);
    if (h) line = vr ? 0 : line + 1;
    if (rst) begin
      // Reset lands in the pre-sync blank; sync is only reached if the
      // sync-start line is still ahead in this frame.
      pend = (line >= vs);
      merr = 0; seen = 0; len = 0;
    end else if (h && vr) begin
      pend = 0;
      if (seen && (len + 1) != lines) merr = 1;
      seen = 1; len = 0;
    end else if (h) begin
      len++;
    end
  endtask

  task automatic check_dut(input string tag, input int line, input bit pend, input bit merr,
                           input bit ft_exp, input int vs, input int ve, input int be,
                           input logic vb, input logic vbn, input logic vsy, input logic vsn,
                           input logic ft, input logic err);
    bit exp_vb, exp_vs, exp_err;
    exp_vb = pend || (line < be);
    exp_vs = !pend && (line >= vs) && (line < ve);
`ifdef VTIMING_CHECK_EN
    exp_err = merr;
`else
    exp_err = 1'b0;
`endif
    chk({tag, "_vblank"},   line, vb,  exp_vb);
    chk({tag, "_vblank_n"}, line, vbn, !exp_vb);
    chk({tag, "_vsync"},    line, vsy, exp_vs);
    chk({tag, "_vsync_n"},  line, vsn, !exp_vs);
    chk({tag, "_ftick"},    line, ft,  ft_exp);
    chk({tag, "_terr"},     line, err, exp_err);
  endtask

  task automatic tick(input bit h, input bit rst, input bit vforce);
    @(negedge clk);
    hres   = h;
    rstn   = !rst;
    vcnt_a = 9'(line_a);
    vres_a = (line_a == last_a) || vforce;
    vcnt_b = 9'(line_b);
    vres_b = (line_b == 19) || vforce;
    @(posedge clk);
    ft_exp_a = !rst && h && vres_a;
    ft_exp_b = !rst && h && vres_b;
    model(line_a, pend_a, merr_a, seen_a, len_a, h, vres_a, rst, 262, 4);
    model(line_b, pend_b, merr_b, seen_b, len_b, h, vres_b, rst, 20, 2);
    #1;
    check_dut("A", line_a, pend_a, merr_a, ft_exp_a, 4, 8, 16,
              vb_a, vbn_a, vs_a, vsn_a, ft_a, err_a);
    check_dut("B", line_b, pend_b, merr_b, ft_exp_b, 2, 16, 16,
              vb_b, vbn_b, vs_b, vsn_b, ft_b, err_b);
  endtask

  task automatic next_line();
    repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++) next_line();
  endtask

  task automatic run_to_line(input int target);
    for (int i = 0; i < 1000 && line_a != target; i++) next_line();
    checks++;
    if (line_a != target) begin
      errors++;
      $display("FAIL run_to_line reached=%0d required=%0d", line_a, target);
    end
  endtask

  initial begin
    hres = 1'b0; rstn = 1'b0; vres_a = 1'b0; vres_b = 1'b0;
    vcnt_a = '0; vcnt_b = '0;

    // Reset state, then three full frames of normal timing.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    run_lines(262 * 3);

    // VRESET high without HRESET must be ignored.
    run_to_line(50);
    repeat (3) tick(1'b0, 1'b0, 1'b1);

    // Mid-frame reset coincident with HRESET; blank until the next frame.
    run_to_line(100);
    tick(1'b1, 1'b1, 1'b0);
    run_to_line(0);
    run_lines(262 * 2);

    // One 261-line frame raises the sticky error; good frames keep it.
    run_to_line(10);
    last_a = 260;
    run_to_line(0);
    last_a = 261;
    run_lines(262 * 2);

    // Reset clears the error flag.
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    run_lines(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
